// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: memory access lengths, FSM state codes and
// the half-word extension helper used when reassembling split loads.
package load_store_unit_pkg;

  localparam logic [1:0] MEM_LEN_NONE = 2'b00;
  localparam logic [1:0] MEM_LEN_BYTE = 2'b01;
  localparam logic [1:0] MEM_LEN_HALF = 2'b10;
  localparam logic [1:0] MEM_LEN_WORD = 2'b11;

  typedef enum logic [1:0] {
    LSU_IDLE    = 2'b00,
    LSU_ALIGNED = 2'b01,
    LSU_SPLIT   = 2'b10,
    LSU_RESP    = 2'b11
  } lsu_state_e;

  function automatic logic [31:0] ext_half(input logic [15:0] i_half, input logic i_signed);
    return {{16{i_signed & i_half[15]}}, i_half};
  endfunction

endpackage

// File: rtl/load_store_unit_align_check.sv
// Classifies a request by size and low address bits: natural alignment, illegal size,
// and the number of bytes the access covers.
module load_store_unit_align_check
  import load_store_unit_pkg::*;
(
  input  logic [1:0] i_size,
  input  logic [1:0] i_addr_lo,
  output logic       o_aligned,
  output logic       o_illegal,
  output logic [2:0] o_nbytes
);

  always_comb begin
    o_aligned = 1'b0;
    o_illegal = 1'b0;
    o_nbytes  = 3'd0;
    case (i_size)
      MEM_LEN_BYTE: begin
        o_aligned = 1'b1;
        o_nbytes  = 3'd1;
      end
      MEM_LEN_HALF: begin
        o_aligned = ~i_addr_lo[0];
        o_nbytes  = 3'd2;
      end
      MEM_LEN_WORD: begin
        o_aligned = (i_addr_lo == 2'b00);
        o_nbytes  = 3'd4;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-port initiator: one request at a time, aligned accesses in a single memory cycle,
// misaligned half/word accesses either split into byte accesses or rejected with an error.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MISALIGN_TRAP = 0
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  MEM_write_length,
  output logic [31:0] MEM_write_address,
  output logic [31:0] MEM_write_data,
  output logic [1:0]  MEM_read_length,
  output logic        MEM_read_signed,
  output logic [31:0] MEM_read_address,
  input  logic [31:0] MEM_read_data
);

  lsu_state_e  r_state;
  logic [1:0]  r_cnt;
  logic [1:0]  r_last;
  logic [1:0]  r_size;
  logic        r_write;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;
  logic [1:0]  r_mem_wlen;
  logic [31:0] r_mem_waddr;
  logic [31:0] r_mem_wdata;
  logic [1:0]  r_mem_rlen;
  logic        r_mem_rsigned;
  logic [31:0] r_mem_raddr;

  logic        w_aligned;
  logic        w_illegal;
  logic [2:0]  w_nbytes;
  logic        w_trap;
  logic [1:0]  w_next_cnt;
  logic [31:0] w_next_addr;
  logic [7:0]  w_next_wbyte;
  logic [31:0] w_cap_rdata;
  logic [31:0] w_split_result;

  load_store_unit_align_check u_align_check (
    .i_size    (req_size),
    .i_addr_lo (req_addr[1:0]),
    .o_aligned (w_aligned),
    .o_illegal (w_illegal),
    .o_nbytes  (w_nbytes)
  );

  assign w_trap       = w_illegal | (~w_aligned & (MISALIGN_TRAP != 0));
  assign w_next_cnt   = r_cnt + 2'd1;
  assign w_next_addr  = r_addr + {30'd0, w_next_cnt};
  assign w_next_wbyte = r_wdata[{w_next_cnt, 3'b000} +: 8];

  // Merge the byte returned this cycle into the partial result; a split half is extended here.
  always_comb begin
    w_cap_rdata = r_rdata;
    w_cap_rdata[{r_cnt, 3'b000} +: 8] = MEM_read_data[7:0];
    w_split_result = (r_size == MEM_LEN_HALF) ? ext_half(w_cap_rdata[15:0], r_signed)
                                              : w_cap_rdata;
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      r_state       <= LSU_IDLE;
      r_cnt         <= 2'd0;
      r_last        <= 2'd0;
      r_size        <= MEM_LEN_NONE;
      r_write       <= 1'b0;
      r_signed      <= 1'b0;
      r_addr        <= 32'd0;
      r_wdata       <= 32'd0;
      r_rdata       <= 32'd0;
      r_req_ready   <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_err    <= 1'b0;
      r_resp_rdata  <= 32'd0;
      r_mem_wlen    <= MEM_LEN_NONE;
      r_mem_waddr   <= 32'd0;
      r_mem_wdata   <= 32'd0;
      r_mem_rlen    <= MEM_LEN_NONE;
      r_mem_rsigned <= 1'b0;
      r_mem_raddr   <= 32'd0;
    end else begin
      // Memory strobes and the response are single-cycle unless re-asserted below.
      r_mem_wlen    <= MEM_LEN_NONE;
      r_mem_waddr   <= 32'd0;
      r_mem_wdata   <= 32'd0;
      r_mem_rlen    <= MEM_LEN_NONE;
      r_mem_rsigned <= 1'b0;
      r_mem_raddr   <= 32'd0;
      r_resp_valid  <= 1'b0;
      r_resp_err    <= 1'b0;
      r_resp_rdata  <= 32'd0;
      case (r_state)
        LSU_IDLE: begin
          if (req_valid) begin
            r_req_ready <= 1'b0;
            r_size      <= req_size;
            r_write     <= req_write;
            r_signed    <= req_signed;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_rdata     <= 32'd0;
            r_cnt       <= 2'd0;
            r_last      <= 2'(w_nbytes - 3'd1);
            if (w_trap) begin
              r_state      <= LSU_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else if (w_aligned) begin
              r_state <= LSU_ALIGNED;
              if (req_write) begin
                r_mem_wlen  <= req_size;
                r_mem_waddr <= req_addr;
                r_mem_wdata <= req_wdata;
              end else begin
                r_mem_rlen    <= req_size;
                r_mem_rsigned <= req_signed;
                r_mem_raddr   <= req_addr;
              end
            end else begin
              r_state <= LSU_SPLIT;
              if (req_write) begin
                r_mem_wlen  <= MEM_LEN_BYTE;
                r_mem_waddr <= req_addr;
                r_mem_wdata <= {24'd0, req_wdata[7:0]};
              end else begin
                r_mem_rlen  <= MEM_LEN_BYTE;
                r_mem_raddr <= req_addr;
              end
            end
          end
        end
        LSU_ALIGNED: begin
          r_state      <= LSU_RESP;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= r_write ? 32'd0 : MEM_read_data;
        end
        LSU_SPLIT: begin
          if (r_cnt == r_last) begin
            r_state      <= LSU_RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_write ? 32'd0 : w_split_result;
          end else begin
            r_cnt <= w_next_cnt;
            if (r_write) begin
              r_mem_wlen  <= MEM_LEN_BYTE;
              r_mem_waddr <= w_next_addr;
              r_mem_wdata <= {24'd0, w_next_wbyte};
            end else begin
              r_rdata     <= w_cap_rdata;
              r_mem_rlen  <= MEM_LEN_BYTE;
              r_mem_raddr <= w_next_addr;
            end
          end
        end
        LSU_RESP: begin
          r_state     <= LSU_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready         = r_req_ready;
  assign resp_valid        = r_resp_valid;
  assign resp_rdata        = r_resp_rdata;
  assign resp_err          = r_resp_err;
  assign MEM_write_length  = r_mem_wlen;
  assign MEM_write_address = r_mem_waddr;
  assign MEM_write_data    = r_mem_wdata;
  assign MEM_read_length   = r_mem_rlen;
  assign MEM_read_signed   = r_mem_rsigned;
  assign MEM_read_address  = r_mem_raddr;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: a split-mode unit driving a byte-array memory model, plus a trapping
// instance fed the same requests to observe misalignment rejection.
module tb_load_store_unit;

  logic        SYS_clk;
  logic        SYS_reset_n;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  MEM_write_length;
  logic [31:0] MEM_write_address;
  logic [31:0] MEM_write_data;
  logic [1:0]  MEM_read_length;
  logic        MEM_read_signed;
  logic [31:0] MEM_read_address;
  logic [31:0] mem_rdata;

  logic        t_req_ready;
  logic        t_resp_valid;
  logic [31:0] t_resp_rdata;
  logic        t_resp_err;
  logic [1:0]  t_wlen;
  logic [31:0] t_waddr;
  logic [31:0] t_wdata;
  logic [1:0]  t_rlen;
  logic        t_rsigned;
  logic [31:0] t_raddr;
  logic [31:0] t_mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  load_store_unit #(.MISALIGN_TRAP(0)) u_dut (
    .SYS_clk(SYS_clk), .SYS_reset_n(SYS_reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .MEM_write_length(MEM_write_length), .MEM_write_address(MEM_write_address),
    .MEM_write_data(MEM_write_data), .MEM_read_length(MEM_read_length),
    .MEM_read_signed(MEM_read_signed), .MEM_read_address(MEM_read_address),
    .MEM_read_data(mem_rdata)
  );

  load_store_unit #(.MISALIGN_TRAP(1)) u_trap (
    .SYS_clk(SYS_clk), .SYS_reset_n(SYS_reset_n),
    .req_valid(req_valid), .req_ready(t_req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(t_resp_valid), .resp_rdata(t_resp_rdata), .resp_err(t_resp_err),
    .MEM_write_length(t_wlen), .MEM_write_address(t_waddr),
    .MEM_write_data(t_wdata), .MEM_read_length(t_rlen),
    .MEM_read_signed(t_rsigned), .MEM_read_address(t_raddr),
    .MEM_read_data(t_mem_rdata)
  );

  initial SYS_clk = 1'b0;
  always #5 SYS_clk = ~SYS_clk;

  // Little-endian byte memory, 4 KiB window (address bits above 11 ignored).
  logic [7:0]  mem [0:4095];
  logic        pk_en;
  logic [11:0] pk_addr;
  logic [7:0]  pk_data;
  logic [11:0] ra;

  always_comb begin
    ra        = MEM_read_address[11:0];
    mem_rdata = 32'h0;
    case (MEM_read_length)
      2'b01: mem_rdata = {{24{MEM_read_signed & mem[ra][7]}}, mem[ra]};
      2'b10: mem_rdata = {{16{MEM_read_signed & mem[ra + 12'd1][7]}}, mem[ra + 12'd1], mem[ra]};
      2'b11: mem_rdata = {mem[ra + 12'd3], mem[ra + 12'd2], mem[ra + 12'd1], mem[ra]};
      default: mem_rdata = 32'h0;
    endcase
  end

  always @(posedge SYS_clk) begin
    if (pk_en) mem[pk_addr] <= pk_data;
    if (MEM_write_length != 2'b00) mem[MEM_write_address[11:0]] <= MEM_write_data[7:0];
    if (MEM_write_length[1]) mem[MEM_write_address[11:0] + 12'd1] <= MEM_write_data[15:8];
    if (MEM_write_length == 2'b11) begin
      mem[MEM_write_address[11:0] + 12'd2] <= MEM_write_data[23:16];
      mem[MEM_write_address[11:0] + 12'd3] <= MEM_write_data[31:24];
    end
  end

  // Per-transaction observations (cycle index 1 = first cycle after the accept edge).
  logic [31:0] cyc_wlen  [1:6];
  logic [31:0] cyc_waddr [1:6];
  logic [31:0] cyc_wdata [1:6];
  logic [31:0] cyc_rlen  [1:6];
  logic [31:0] cyc_raddr [1:6];
  logic [31:0] cyc_rsgn  [1:6];
  int          lat, t_lat, n_resp, wcnt, rcnt, t_mem_cnt;
  logic [31:0] got_rdata, t_got_rdata;
  logic [31:0] got_err, t_got_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    @(negedge SYS_clk);
    pk_en = 1'b1; pk_addr = a; pk_data = d;
    @(posedge SYS_clk);
    #1 pk_en = 1'b0;
  endtask

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    @(negedge SYS_clk);
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge SYS_clk);
    #1 req_valid = 1'b0;
    lat = 0; t_lat = 0; n_resp = 0; wcnt = 0; rcnt = 0; t_mem_cnt = 0;
    got_rdata = 32'hx; got_err = 32'hx; t_got_rdata = 32'hx; t_got_err = 32'hx;
    for (int c = 1; c <= 6; c++) begin
      @(negedge SYS_clk);
      cyc_wlen[c]  = {30'd0, MEM_write_length};
      cyc_waddr[c] = MEM_write_address;
      cyc_wdata[c] = MEM_write_data;
      cyc_rlen[c]  = {30'd0, MEM_read_length};
      cyc_raddr[c] = MEM_read_address;
      cyc_rsgn[c]  = {31'd0, MEM_read_signed};
      if (MEM_write_length != 2'b00) wcnt++;
      if (MEM_read_length != 2'b00) rcnt++;
      if (t_wlen != 2'b00 || t_rlen != 2'b00) t_mem_cnt++;
      if (resp_valid) begin
        n_resp++;
        if (lat == 0) begin
          lat = c; got_rdata = resp_rdata; got_err = {31'd0, resp_err};
        end
      end
      if (t_resp_valid && t_lat == 0) begin
        t_lat = c; t_got_rdata = t_resp_rdata; t_got_err = {31'd0, t_resp_err};
      end
    end
    $display("txn wr=%0d size=%0d signed=%0d addr=%h wdata=%h -> lat=%0d rdata=%h err=%0h",
             wr, sz, sg, a, wd, lat, got_rdata, got_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pk_en = 1'b0; pk_addr = 12'd0; pk_data = 8'd0; t_mem_rdata = 32'h0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    SYS_reset_n = 1'b1;
    #1 SYS_reset_n = 1'b0;
    repeat (2) @(negedge SYS_clk);

    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_wlen", {30'd0, MEM_write_length}, 32'd0);
    chk("rst_rlen", {30'd0, MEM_read_length}, 32'd0);
    chk("rst_waddr", MEM_write_address, 32'd0);
    chk("rst_wdata", MEM_write_data, 32'd0);
    chk("rst_raddr", MEM_read_address, 32'd0);
    chk("rst_rsigned", {31'd0, MEM_read_signed}, 32'd0);
    SYS_reset_n = 1'b1;

    // Aligned word store then load
    do_req(1'b1, 2'b11, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
    chk("sw_lat", lat, 32'd2);
    chk("sw_wlen", cyc_wlen[1], 32'd3);
    chk("sw_waddr", cyc_waddr[1], 32'h100);
    chk("sw_wdata", cyc_wdata[1], 32'hDEAD_BEEF);
    chk("sw_write_cycles", wcnt, 32'd1);
    chk("sw_rdata", got_rdata, 32'd0);
    chk("sw_err", got_err, 32'd0);
    chk("sw_resp_pulses", n_resp, 32'd1);
    do_req(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'd0);
    chk("lw_lat", lat, 32'd2);
    chk("lw_rlen", cyc_rlen[1], 32'd3);
    chk("lw_raddr", cyc_raddr[1], 32'h100);
    chk("lw_rdata", got_rdata, 32'hDEAD_BEEF);
    chk("lw_read_cycles", rcnt, 32'd1);

    // Byte loads, signed and unsigned
    poke(12'h203, 8'h80);
    do_req(1'b0, 2'b01, 1'b1, 32'h0000_0203, 32'd0);
    chk("lb_rdata", got_rdata, 32'hFFFF_FF80);
    chk("lb_rlen", cyc_rlen[1], 32'd1);
    chk("lb_rsigned", cyc_rsgn[1], 32'd1);
    chk("lb_read_cycles", rcnt, 32'd1);
    chk("lb_lat", lat, 32'd2);
    do_req(1'b0, 2'b01, 1'b0, 32'h0000_0203, 32'd0);
    chk("lbu_rdata", got_rdata, 32'h0000_0080);

    // Misaligned word load split into four byte reads
    poke(12'h101, 8'h11); poke(12'h102, 8'h22); poke(12'h103, 8'h33); poke(12'h104, 8'h44);
    do_req(1'b0, 2'b11, 1'b0, 32'h0000_0101, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      chk("splitlw_rlen", cyc_rlen[k], 32'd1);
      chk("splitlw_raddr", cyc_raddr[k], 32'h100 + k);
      chk("splitlw_rsigned", cyc_rsgn[k], 32'd0);
    end
    chk("splitlw_lat", lat, 32'd5);
    chk("splitlw_rdata", got_rdata, 32'h4433_2211);
    chk("trap_lw_err", t_got_err, 32'd1);

    // Misaligned half load across a 1 KiB boundary
    poke(12'h3FF, 8'h34); poke(12'h400, 8'h92);
    do_req(1'b0, 2'b10, 1'b1, 32'h0000_03FF, 32'd0);
    chk("splitlh_lat", lat, 32'd3);
    chk("splitlh_rdata", got_rdata, 32'hFFFF_9234);
    chk("trap_lh_lat", t_lat, 32'd1);
    chk("trap_lh_err", t_got_err, 32'd1);
    chk("trap_lh_rdata", t_got_rdata, 32'd0);
    chk("trap_lh_mem_cycles", t_mem_cnt, 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_03FF, 32'd0);
    chk("splitlhu_rdata", got_rdata, 32'h0000_9234);

    // Half store wrapping past the top of the address space
    do_req(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0000_ABCD);
    chk("wrapsh_wlen0", cyc_wlen[1], 32'd1);
    chk("wrapsh_waddr0", cyc_waddr[1], 32'hFFFF_FFFF);
    chk("wrapsh_wdata0", cyc_wdata[1], 32'h0000_00CD);
    chk("wrapsh_wlen1", cyc_wlen[2], 32'd1);
    chk("wrapsh_waddr1", cyc_waddr[2], 32'h0000_0000);
    chk("wrapsh_wdata1", cyc_wdata[2], 32'h0000_00AB);
    chk("wrapsh_lat", lat, 32'd3);
    chk("wrapsh_write_cycles", wcnt, 32'd2);
    do_req(1'b0, 2'b01, 1'b0, 32'h0000_0000, 32'd0);
    chk("wrapsh_readback", got_rdata, 32'h0000_00AB);

    // Illegal size
    do_req(1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'd0);
    chk("size0_lat", lat, 32'd1);
    chk("size0_err", got_err, 32'd1);
    chk("size0_rdata", got_rdata, 32'd0);
    chk("size0_mem_cycles", wcnt + rcnt, 32'd0);

    // Reset during the second byte of a split store
    poke(12'h202, 8'hEE);
    @(negedge SYS_clk);
    req_write = 1'b1; req_size = 2'b11; req_signed = 1'b0;
    req_addr = 32'h0000_0201; req_wdata = 32'h1122_3344; req_valid = 1'b1;
    @(posedge SYS_clk);
    #1 req_valid = 1'b0;
    @(negedge SYS_clk);
    chk("rstsw_wdata0", MEM_write_data, 32'h0000_0044);
    @(negedge SYS_clk);
    chk("rstsw_wlen1", {30'd0, MEM_write_length}, 32'd1);
    chk("rstsw_waddr1", MEM_write_address, 32'h0000_0202);
    #1 SYS_reset_n = 1'b0;
    #1;
    chk("rstsw_wlen_cut", {30'd0, MEM_write_length}, 32'd0);
    chk("rstsw_waddr_cut", MEM_write_address, 32'd0);
    chk("rstsw_ready", {31'd0, req_ready}, 32'd1);
    req_write = 1'b1; req_size = 2'b01; req_addr = 32'h0000_0300; req_wdata = 32'h0000_005A;
    req_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge SYS_clk);
      chk("rstsw_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    SYS_reset_n = 1'b1;
    @(negedge SYS_clk);
    chk("held_acc_wlen", {30'd0, MEM_write_length}, 32'd1);
    chk("held_acc_waddr", MEM_write_address, 32'h0000_0300);
    chk("held_acc_ready", {31'd0, req_ready}, 32'd0);
    @(negedge SYS_clk);
    chk("held_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("held_resp_ready", {31'd0, req_ready}, 32'd0);
    @(negedge SYS_clk);
    chk("held_not_accepted", {30'd0, MEM_write_length}, 32'd0);
    chk("held_idle_ready", {31'd0, req_ready}, 32'd1);
    @(negedge SYS_clk);
    chk("held_reaccept_wlen", {30'd0, MEM_write_length}, 32'd1);
    req_valid = 1'b0;
    repeat (3) @(negedge SYS_clk);
    $display("txn reset-during-split sequence done");

    do_req(1'b0, 2'b01, 1'b0, 32'h0000_0201, 32'd0);
    chk("rstsw_byte0_committed", got_rdata, 32'h0000_0044);
    do_req(1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'd0);
    chk("rstsw_byte1_cut", got_rdata, 32'h0000_00EE);
    do_req(1'b0, 2'b01, 1'b0, 32'h0000_0300, 32'd0);
    chk("held_store_data", got_rdata, 32'h0000_005A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
